// File: rtl/data_mem_write_buffer_if.sv
// data_mem_write_buffer_if
//   Bundles the store, load-forward and memory-drain signals of the
//   write-through store buffer into one interface.
//   Ports (as seen by the buffer, modport slave):
//     A, WD, WE        store request from the data cache
//     Full, Empty      buffer occupancy flags
//     Count            number of valid entries
//     RA               load address for the forward lookup
//     FwdHit, FwdData  forwarded store data for the load
//     MemA, MemWD      head entry presented to main memory
//     MemWE            head valid / memory write request
//     MemReady         memory accepts the head this cycle
//   modport master is the environment side (cache + memory) of the same bus.
interface data_mem_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 11,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] A;
  logic [DW-1:0] WD;
  logic          WE;
  logic          Full;
  logic          Empty;
  logic [CW-1:0] Count;
  logic [AW-1:0] RA;
  logic          FwdHit;
  logic [DW-1:0] FwdData;
  logic [AW-1:0] MemA;
  logic [DW-1:0] MemWD;
  logic          MemWE;
  logic          MemReady;

  modport slave (
    input  A, WD, WE, RA, MemReady,
    output Full, Empty, Count, FwdHit, FwdData, MemA, MemWD, MemWE
  );

  modport master (
    output A, WD, WE, RA, MemReady,
    input  Full, Empty, Count, FwdHit, FwdData, MemA, MemWD, MemWE
  );
endinterface

// File: rtl/data_mem_write_buffer.sv
// data_mem_write_buffer
//   Write-through store buffer between the data cache and main data memory.
//   Stores are queued as {word address, data} in a circular FIFO and drained
//   to memory one word per accepted handshake. Queued store data is forwarded
//   to loads so memory reads never observe stale data.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   data_mem_write_buffer_if.slave (store, forward and memory sides)
//   Optional feature: define WB_COALESCE_EN to merge a store into the youngest
//   entry when it hits the same word and that entry is not the head.
module data_mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 11,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  data_mem_write_buffer_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = AW - 2;

  logic [WW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          coalesce;
  logic [WW-1:0] st_word;
  logic [WW-1:0] ld_word;
  logic [PW-1:0] idx;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  assign st_word = bus.A[AW-1:2];
  assign ld_word = bus.RA[AW-1:2];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

`ifdef WB_COALESCE_EN
  logic [PW-1:0] tail_ptr;

  // The head is never merged into because it may be mid-handshake with
  // memory, hence the Count>=2 requirement. A merge is legal even when full.
  assign tail_ptr = wr_ptr - PW'(1);
  assign coalesce = bus.WE && (count >= CW'(2)) && (addr_q[tail_ptr] == st_word);
`else
  assign coalesce = 1'b0;
`endif

  // Full is judged on the registered count, so a pop in the same cycle does
  // not make room for a push.
  assign push = bus.WE && !full && !coalesce;
  assign pop  = !empty && bus.MemReady;

  // FIFO storage, pointers and the explicit occupancy count. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= st_word;
        data_q[wr_ptr] <= bus.WD;
        wr_ptr         <= wr_ptr + PW'(1);
      end
`ifdef WB_COALESCE_EN
      if (coalesce) begin
        data_q[tail_ptr] <= bus.WD;
      end
`endif
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Load forwarding. Valid entries are scanned oldest to youngest so the
  // youngest match wins; an incoming accepted store overrides everything.
  // Reset suppresses the incoming-store path so the outputs read zero.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx] == ld_word)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
    if (!rst && bus.WE && !full && (st_word == ld_word)) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.WD;
    end
  end

  assign bus.Full    = full;
  assign bus.Empty   = empty;
  assign bus.Count   = count;
  assign bus.MemWE   = !empty;
  assign bus.MemA    = empty ? '0 : {addr_q[rd_ptr], 2'b00};
  assign bus.MemWD   = empty ? '0 : data_q[rd_ptr];
  assign bus.FwdHit  = fwd_hit;
  assign bus.FwdData = fwd_data;
endmodule

// File: tb/tb_data_mem_write_buffer.sv
// tb_data_mem_write_buffer
//   Self-checking bench for data_mem_write_buffer. The expected memory write
//   stream is a queue of {word, data} kept by the stimulus side; a monitor on
//   the falling edge compares flags, forwarding and drained writes against it.
//   Build with or without WB_COALESCE_EN; the reference adapts to the macro.
module tb_data_mem_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int WW    = AW - 2;

`ifdef WB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  typedef struct {
    logic [WW-1:0] word;
    logic [DW-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  // Reference contents of the buffer, oldest first: also the expected
  // order of writes reaching memory.
  entry_t pending[$];

  always #5 clk = ~clk;

  data_mem_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  data_mem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  // Called just after a rising edge: drives one cycle of inputs, decides from
  // the reference what the buffer must do with the store, and commits that at
  // the next rising edge.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                               input logic mr);
    bit     do_coal;
    bit     do_push;
    entry_t e;
    bus.WE       = we;
    bus.A        = a;
    bus.WD       = wd;
    bus.RA       = ra;
    bus.MemReady = mr;
    do_coal = COAL && we && (pending.size() >= 2) && (pending[pending.size()-1].word == a[AW-1:2]);
    do_push = we && !do_coal && (pending.size() < DEPTH);
    @(posedge clk);
    if (do_coal) begin
      e = pending.pop_back();
      e.data = wd;
      pending.push_back(e);
    end else if (do_push) begin
      e.word = a[AW-1:2];
      e.data = wd;
      pending.push_back(e);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && pending.size() != 0; i++) applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("drain Empty", 64'(bus.Empty), 64'(1));
    checkOutput("drain leftover", 64'(pending.size()), 64'(0));
  endtask

  // Monitor: flags and forwarding against the reference, then each accepted
  // memory write against the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic          exp_hit;
    logic [DW-1:0] exp_fwd;
    entry_t        head;
    if (!rst) begin
      checkOutput("Count", 64'(bus.Count), 64'(pending.size()));
      checkOutput("Full", 64'(bus.Full), 64'(pending.size() == DEPTH));
      checkOutput("Empty", 64'(bus.Empty), 64'(pending.size() == 0));
      checkOutput("MemWE", 64'(bus.MemWE), 64'(pending.size() != 0));
      exp_hit = 1'b0;
      exp_fwd = '0;
      foreach (pending[i]) begin
        if (pending[i].word == bus.RA[AW-1:2]) begin
          exp_hit = 1'b1;
          exp_fwd = pending[i].data;
        end
      end
      if (bus.WE && pending.size() < DEPTH && bus.A[AW-1:2] == bus.RA[AW-1:2]) begin
        exp_hit = 1'b1;
        exp_fwd = bus.WD;
      end
      checkOutput("FwdHit", 64'(bus.FwdHit), 64'(exp_hit));
      checkOutput("FwdData", 64'(bus.FwdData), 64'(exp_fwd));
      if (bus.MemWE && bus.MemReady) begin
        if (pending.size() == 0) begin
          checkOutput("unexpected memory write", 64'(1), 64'(0));
        end else begin
          head = pending.pop_front();
          checkOutput("MemA", 64'(bus.MemA), 64'({head.word, 2'b00}));
          checkOutput("MemWD", 64'(bus.MemWD), 64'(head.data));
        end
      end
    end
  end

  initial begin
    bus.A = '0; bus.WD = '0; bus.WE = 1'b0; bus.RA = '0; bus.MemReady = 1'b0;
    #1 rst = 1'b1;
    #2;
    checkOutput("reset Count", 64'(bus.Count), 64'(0));
    checkOutput("reset Empty", 64'(bus.Empty), 64'(1));
    checkOutput("reset Full", 64'(bus.Full), 64'(0));
    checkOutput("reset MemWE", 64'(bus.MemWE), 64'(0));
    checkOutput("reset MemA", 64'(bus.MemA), 64'(0));
    checkOutput("reset FwdHit", 64'(bus.FwdHit), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency: store into empty buffer is presented to memory next cycle.
    applyStimulus(1'b1, 11'h010, 32'hDEADBEEF, '0, 1'b1);
    checkOutput("latency MemWE", 64'(bus.MemWE), 64'(1));
    checkOutput("latency MemA", 64'(bus.MemA), 64'h010);
    checkOutput("latency MemWD", 64'(bus.MemWD), 64'hDEADBEEF);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("latency Empty", 64'(bus.Empty), 64'(1));

    // Full: four stores with memory stalled, fifth is dropped.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, AW'(4 * i), DW'(32'hA0 + i), '0, 1'b0);
    checkOutput("full Full", 64'(bus.Full), 64'(1));
    applyStimulus(1'b1, 11'h010, 32'h55, '0, 1'b0);
    checkOutput("full drop Count", 64'(bus.Count), 64'(4));
    drain();

    // Wrap: ten back-to-back push/pop pairs.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, AW'(11'h100 + 4 * i), DW'($urandom), '0, 1'b1);
    drain();

    // Forwarding: youngest entry, same-cycle store, and a miss.
    applyStimulus(1'b1, 11'h020, 32'h11, '0, 1'b0);
    applyStimulus(1'b1, 11'h020, 32'h22, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 11'h022, 1'b0);
    checkOutput("fwd youngest hit", 64'(bus.FwdHit), 64'(1));
    checkOutput("fwd youngest data", 64'(bus.FwdData), 64'h22);
    applyStimulus(1'b1, 11'h020, 32'h33, 11'h022, 1'b0);
    checkOutput("fwd incoming data", 64'(bus.FwdData), 64'h33);
    applyStimulus(1'b0, '0, '0, 11'h024, 1'b0);
    checkOutput("fwd miss", 64'(bus.FwdHit), 64'(0));
    drain();

    // Coalesce: two stores to the same non-head word.
    applyStimulus(1'b1, 11'h000, 32'h1, '0, 1'b0);
    applyStimulus(1'b1, 11'h040, 32'h2, '0, 1'b0);
    applyStimulus(1'b1, 11'h040, 32'h3, '0, 1'b0);
    checkOutput("coalesce Count", 64'(bus.Count), COAL ? 64'(2) : 64'(3));
    drain();

    // Reset mid-drain with three entries left takes effect without a clock.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, AW'(11'h200 + 4 * i), DW'(i + 7), '0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    checkOutput("pre-reset Count", 64'(bus.Count), 64'(3));
    #1 rst = 1'b1;
    #1;
    checkOutput("async reset Count", 64'(bus.Count), 64'(0));
    checkOutput("async reset Empty", 64'(bus.Empty), 64'(1));
    checkOutput("async reset MemWE", 64'(bus.MemWE), 64'(0));
    pending.delete();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomised traffic on a small address pool so hits and merges occur.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    AW'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3)),
                    DW'($urandom),
                    AW'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3)),
                    1'($urandom_range(0, 2) == 0));
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
